dmem_bridge: RTL and testbench

Memory-stage data-memory bridge for the pipelined RISC-V core. It consumes the M-stage access signals (address, store data, funct3, read/write strobes) and converts each access into one transaction on a word-wide valid/ready bus with byte strobes. It holds the core with `StallM` until the bus responds, then returns the lane-aligned, sign- or zero-extended load data on `ReadDataM`. It also flags misaligned accesses, unsupported sizes, bus errors and timeouts.

---
 rtl/dmem_bridge_pkg.sv | 37 +++
 rtl/dmem_bridge_load_ext.sv | 48 ++++
 rtl/dmem_bridge.sv | 195 +++++++++++++++++++
 tb/tb_dmem_bridge.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_bridge_pkg.sv
// dmem_pkg: shared definitions for the M-stage data-memory bridge.
//   - dmem_state_e    : bridge FSM states
//   - F3_*            : funct3 encodings of the supported load/store sizes
//   - is_legal_access : size/alignment/direction legality of an access
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } dmem_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Unsigned variants only exist for loads; halfwords need addr[0]=0,
    // words need addr[1:0]=0. Anything else is rejected.
    function automatic logic is_legal_access(input logic [2:0] funct3,
                                             input logic [1:0] addr_lo,
                                             input logic       is_write);
        logic legal;
        case (funct3)
            F3_B:    legal = 1'b1;
            F3_H:    legal = ~addr_lo[0];
            F3_W:    legal = (addr_lo == 2'b00);
            F3_BU:   legal = ~is_write;
            F3_HU:   legal = ~is_write & ~addr_lo[0];
            default: legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/dmem_bridge_load_ext.sv
// dmem_load_ext: picks the addressed byte/halfword out of a bus read word and
// sign- or zero-extends it according to funct3.
//   word_i    : 32-bit word returned by the bus
//   addr_lo_i : byte offset of the access (addr[1:0])
//   funct3_i  : load size/signedness
//   data_o    : extended, LSB-aligned load data
module dmem_load_ext
    import dmem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane select: byte by addr[1:0], halfword by addr[1].
    always_comb begin
        byte_s = 8'h00;
        case (addr_lo_i)
            2'd0:    byte_s = word_i[7:0];
            2'd1:    byte_s = word_i[15:8];
            2'd2:    byte_s = word_i[23:16];
            2'd3:    byte_s = word_i[31:24];
            default: byte_s = 8'h00;
        endcase
        if (addr_lo_i[1]) begin
            half_s = word_i[31:16];
        end else begin
            half_s = word_i[15:0];
        end
    end

    // Extension by size and signedness.
    always_comb begin
        data_o = 32'h0000_0000;
        case (funct3_i)
            F3_B:    data_o = {{24{byte_s[7]}}, byte_s};
            F3_BU:   data_o = {24'h00_0000, byte_s};
            F3_H:    data_o = {{16{half_s[15]}}, half_s};
            F3_HU:   data_o = {16'h0000, half_s};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/dmem_bridge.sv
// dmem_bridge: turns each M-stage load/store into one transaction on a
// word-wide valid/ready bus, stalls the core until the response arrives and
// returns extended load data.
//   clk, reset                  : clock, asynchronous active-low reset
//   MemReadM/MemWriteM/InstrM   : access request and funct3 (write wins)
//   ALUResultM/WriteDataM       : byte address and LSB-aligned store data
//   ReadDataM/StallM            : load result (valid in DONE), pipeline stall
//   MisalignM/BusErrM           : illegal access pulse, bus error/timeout pulse
//   bus_*                       : request (valid/ready) and response channel
module dmem_bridge
    import dmem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [2:0]  InstrM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        StallM,
    output logic        MisalignM,
    output logic        BusErrM,
    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic [31:0] bus_addr,
    output logic        bus_we,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic        bus_rsp_valid,
    input  logic [31:0] bus_rdata,
    input  logic        bus_rsp_err
);

    // The counter holds 0..TIMEOUT_CYCLES-1; reaching the last value means
    // this is the TIMEOUT_CYCLES-th cycle spent in REQ/WAIT.
    localparam int unsigned    CNT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    dmem_state_e      state_q, state_d;
    logic [31:0]      addr_q, addr_d;
    logic [2:0]       f3_q, f3_d;
    logic             we_q, we_d;
    logic [3:0]       wstrb_q, wstrb_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             err_q, err_d;

    logic             access_s;
    logic             legal_s;
    logic             timeout_s;
    logic [3:0]       lane_wstrb_s;
    logic [31:0]      lane_wdata_s;
    logic [31:0]      ext_data_s;

    dmem_load_ext u_load_ext (
        .word_i    (bus_rdata),
        .addr_lo_i (addr_q[1:0]),
        .funct3_i  (f3_q),
        .data_o    (ext_data_s)
    );

    // Access decode and store lane replication from the live M-stage inputs.
    always_comb begin
        access_s     = MemReadM | MemWriteM;
        legal_s      = is_legal_access(InstrM, ALUResultM[1:0], MemWriteM);
        timeout_s    = (cnt_q == CNT_LAST);
        lane_wstrb_s = 4'hF;
        lane_wdata_s = WriteDataM;
        case (InstrM[1:0])
            2'b00: begin
                lane_wstrb_s = 4'b0001 << ALUResultM[1:0];
                lane_wdata_s = {4{WriteDataM[7:0]}};
            end
            2'b01: begin
                lane_wstrb_s = 4'b0011 << {ALUResultM[1], 1'b0};
                lane_wdata_s = {2{WriteDataM[15:0]}};
            end
            default: begin
                lane_wstrb_s = 4'hF;
                lane_wdata_s = WriteDataM;
            end
        endcase
    end

    // Next-state, latch and capture logic.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        f3_d    = f3_q;
        we_d    = we_q;
        wstrb_d = wstrb_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (access_s && legal_s) begin
                    addr_d  = ALUResultM;
                    f3_d    = InstrM;
                    we_d    = MemWriteM;
                    wstrb_d = lane_wstrb_s;
                    wdata_d = lane_wdata_s;
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (timeout_s) begin
                    rdata_d = 32'h0000_0000;
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else if (bus_req_ready) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A response in the timeout cycle takes priority.
                if (bus_rsp_valid) begin
                    rdata_d = we_q ? 32'h0000_0000 : ext_data_s;
                    err_d   = bus_rsp_err;
                    state_d = ST_DONE;
                end else if (timeout_s) begin
                    rdata_d = 32'h0000_0000;
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, latches, counter and captures.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            addr_q  <= 32'h0000_0000;
            f3_q    <= 3'b000;
            we_q    <= 1'b0;
            wstrb_q <= 4'h0;
            wdata_q <= 32'h0000_0000;
            cnt_q   <= {CNT_W{1'b0}};
            rdata_q <= 32'h0000_0000;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            f3_q    <= f3_d;
            we_q    <= we_d;
            wstrb_q <= wstrb_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Outputs. StallM/MisalignM are combinational in IDLE, so they are gated
    // with reset to stay low while the bridge is held in reset.
    always_comb begin
        StallM        = reset & (((state_q == ST_IDLE) & access_s & legal_s) |
                                 (state_q == ST_REQ) | (state_q == ST_WAIT));
        MisalignM     = reset & (state_q == ST_IDLE) & access_s & ~legal_s;
        bus_req_valid = (state_q == ST_REQ);
        bus_addr      = {addr_q[31:2], 2'b00};
        bus_we        = we_q;
        bus_wstrb     = wstrb_q;
        bus_wdata     = wdata_q;
        if (state_q == ST_DONE) begin
            ReadDataM = rdata_q;
            BusErrM   = err_q;
        end else begin
            ReadDataM = 32'h0000_0000;
            BusErrM   = 1'b0;
        end
    end

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed bench for dmem_bridge: each access pushes its expected bus request,
// result and stall length into a scoreboard queue; the entry is popped and
// compared when the bridge reaches DONE.
module tb_dmem_bridge;

    logic        clk;
    logic        reset;
    logic        MemReadM, MemWriteM;
    logic [2:0]  InstrM;
    logic [31:0] ALUResultM, WriteDataM;
    logic [31:0] ReadDataM;
    logic        StallM, MisalignM, BusErrM;
    logic        bus_req_valid, bus_req_ready;
    logic [31:0] bus_addr;
    logic        bus_we;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic        bus_rsp_valid;
    logic [31:0] bus_rdata;
    logic        bus_rsp_err;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic [31:0] data;
        logic        err;
        int          stall;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_mis = 0;

    dmem_bridge #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset(reset),
        .MemReadM(MemReadM), .MemWriteM(MemWriteM), .InstrM(InstrM),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .ReadDataM(ReadDataM), .StallM(StallM), .MisalignM(MisalignM), .BusErrM(BusErrM),
        .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
        .bus_addr(bus_addr), .bus_we(bus_we), .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
        .bus_rsp_valid(bus_rsp_valid), .bus_rdata(bus_rdata), .bus_rsp_err(bus_rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=no_finish expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[8*a +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'h0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'h0, h};
            default: return w;
        endcase
    endfunction

    function automatic logic [3:0] m_strb(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b00:   return 4'b0001 << a;
            2'b01:   return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (f3[1:0])
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    // One legal access: bus responder with programmable ready/response delay.
    task automatic run_access(input string tag, input logic rd, input logic wr,
                              input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                              input int ready_wait, input int rsp_wait, input bit respond,
                              input logic [31:0] rdata, input logic rerr,
                              input bit to_exp, input int exp_stall);
        exp_t        e;
        exp_t        h;
        int          stall;
        int          req_n;
        int          wait_n;
        bit          accepted;
        bit          seen_req;
        bit          stable;
        bit          done;
        logic [31:0] a0, d0;
        logic        we0;
        logic [3:0]  s0;
        stall = 0; req_n = 0; wait_n = 0;
        accepted = 1'b0; seen_req = 1'b0; stable = 1'b1; done = 1'b0;
        a0 = 'x; d0 = 'x; we0 = 1'bx; s0 = 'x;
        e.addr  = {addr[31:2], 2'b00};
        e.we    = wr;
        e.strb  = m_strb(f3, addr[1:0]);
        e.wdata = m_wdata(f3, wd);
        e.data  = (to_exp || wr) ? 32'h0 : m_load(f3, addr[1:0], rdata);
        e.err   = to_exp ? 1'b1 : rerr;
        e.stall = exp_stall;
        sb_q.push_back(e);
        MemReadM = rd; MemWriteM = wr; InstrM = f3; ALUResultM = addr; WriteDataM = wd;
        bus_rdata = rdata; bus_rsp_err = rerr;
        for (int cyc = 0; cyc < 40; cyc++) begin
            bus_req_ready = 1'b0;
            bus_rsp_valid = 1'b0;
            #1;
            if (!StallM) begin
                done = 1'b1;
                break;
            end
            stall++;
            if (bus_req_valid) begin
                if (!seen_req) begin
                    seen_req = 1'b1;
                    a0 = bus_addr; we0 = bus_we; s0 = bus_wstrb; d0 = bus_wdata;
                end else if (bus_addr !== a0 || bus_we !== we0 || bus_wstrb !== s0 || bus_wdata !== d0) begin
                    stable = 1'b0;
                end
                bus_req_ready = (req_n >= ready_wait);
                if (bus_req_ready) accepted = 1'b1;
                req_n++;
            end else if (accepted) begin
                bus_rsp_valid = respond && (wait_n == rsp_wait);
                wait_n++;
            end
            @(negedge clk);
        end
        h = sb_q.pop_front();
        chk({tag, "_done"},   {31'h0, done},   32'h1);
        chk({tag, "_addr"},   a0,              h.addr);
        chk({tag, "_we"},     {31'h0, we0},    {31'h0, h.we});
        chk({tag, "_wstrb"},  {28'h0, s0},     {28'h0, h.strb});
        if (h.we) chk({tag, "_wdata"}, d0, h.wdata);
        chk({tag, "_stable"}, {31'h0, stable}, 32'h1);
        chk({tag, "_stall"},  stall,           h.stall);
        chk({tag, "_rdata"},  ReadDataM,       h.data);
        chk({tag, "_err"},    {31'h0, BusErrM}, {31'h0, h.err});
        chk({tag, "_valid_done"}, {31'h0, bus_req_valid}, 32'h0);
        MemReadM = 1'b0; MemWriteM = 1'b0;
        @(negedge clk);
        #1;
        chk({tag, "_idle_err"},   {31'h0, BusErrM}, 32'h0);
        chk({tag, "_idle_rdata"}, ReadDataM,        32'h0);
    endtask

    // Illegal access: one-cycle check plus confirmation that no request follows.
    task automatic run_misalign(input string tag, input logic rd, input logic wr,
                                input logic [2:0] f3, input logic [31:0] addr);
        MemReadM = rd; MemWriteM = wr; InstrM = f3; ALUResultM = addr; WriteDataM = 32'h1234_5678;
        #1;
        chk({tag, "_mis"},   {31'h0, MisalignM},     32'h1);
        chk({tag, "_stall"}, {31'h0, StallM},        32'h0);
        chk({tag, "_rdata"}, ReadDataM,              32'h0);
        MemReadM = 1'b0; MemWriteM = 1'b0;
        @(negedge clk);
        #1;
        chk({tag, "_noreq"}, {31'h0, bus_req_valid}, 32'h0);
        chk({tag, "_clear"}, {31'h0, MisalignM},     32'h0);
    endtask

    initial begin
        reset = 1'b1;
        MemReadM = 1'b0; MemWriteM = 1'b0; InstrM = 3'b000;
        ALUResultM = 32'h0; WriteDataM = 32'h0;
        bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rdata = 32'h0; bus_rsp_err = 1'b0;
        #1 reset = 1'b0;

        // Reset state, with a legal then an illegal access held at the inputs.
        MemReadM = 1'b1; InstrM = 3'b010; ALUResultM = 32'h0000_0100;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_stall",   {31'h0, StallM},        32'h0);
        chk("rst_valid",   {31'h0, bus_req_valid}, 32'h0);
        chk("rst_rdata",   ReadDataM,              32'h0);
        chk("rst_addr",    bus_addr,               32'h0);
        InstrM = 3'b011;
        #1;
        chk("rst_mis",     {31'h0, MisalignM},     32'h0);
        MemReadM = 1'b0;
        reset = 1'b1;
        @(negedge clk);

        run_access("sw_zw",   1'b0, 1'b1, 3'b010, 32'h0000_0104, 32'hDEAD_BEEF, 0, 0, 1'b1, 32'h0,         1'b0, 1'b0, 3);
        run_access("lb",      1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0,         0, 0, 1'b1, 32'h8012_3456, 1'b0, 1'b0, 3);
        run_access("lbu",     1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0,         0, 0, 1'b1, 32'h8012_3456, 1'b0, 1'b0, 3);
        run_access("sh",      1'b0, 1'b1, 3'b001, 32'h0000_0102, 32'hABCD_1234, 0, 0, 1'b1, 32'h0,         1'b0, 1'b0, 3);
        run_misalign("lh_mis", 1'b1, 1'b0, 3'b001, 32'h0000_0101);
        run_misalign("lw_mis", 1'b1, 1'b0, 3'b010, 32'h0000_0102);
        run_misalign("sbu_bad", 1'b0, 1'b1, 3'b100, 32'h0000_0100);
        run_misalign("f3_rsv", 1'b1, 1'b0, 3'b011, 32'h0000_0100);
        run_access("sb",      1'b0, 1'b1, 3'b000, 32'h0000_0101, 32'h0000_00A5, 0, 0, 1'b1, 32'h0,         1'b0, 1'b0, 3);
        run_access("rw_wr",   1'b1, 1'b1, 3'b010, 32'h0000_0108, 32'h0BAD_F00D, 0, 0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 3);
        run_access("lh",      1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0,         0, 1, 1'b1, 32'h8001_7FFF, 1'b0, 1'b0, 4);
        run_access("lhu",     1'b1, 1'b0, 3'b101, 32'h0000_0100, 32'h0,         0, 0, 1'b1, 32'h1234_F00D, 1'b0, 1'b0, 3);
        run_access("bp_lw",   1'b1, 1'b0, 3'b010, 32'h0000_0200, 32'h0,         4, 0, 1'b1, 32'hCAFE_F00D, 1'b0, 1'b0, 7);
        run_access("buserr",  1'b1, 1'b0, 3'b010, 32'h0000_0204, 32'h0,         0, 0, 1'b1, 32'h5555_AAAA, 1'b1, 1'b0, 3);
        run_access("to_wait", 1'b1, 1'b0, 3'b010, 32'h0000_0208, 32'h0,         0, 0, 1'b0, 32'h1111_2222, 1'b0, 1'b1, 9);
        run_access("to_race", 1'b1, 1'b0, 3'b010, 32'h0000_020C, 32'h0,         0, 6, 1'b1, 32'h3333_4444, 1'b0, 1'b0, 9);
        run_access("to_req",  1'b0, 1'b1, 3'b010, 32'h0000_0210, 32'h7777_8888, 100, 0, 1'b1, 32'h0,       1'b0, 1'b1, 9);

        // Reset during WAIT, then a stale response after release.
        MemReadM = 1'b1; InstrM = 3'b010; ALUResultM = 32'h0000_0300; bus_req_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("mr_req", {31'h0, bus_req_valid}, 32'h1);
        @(negedge clk);
        bus_req_ready = 1'b0;
        #1;
        chk("mr_wait_stall", {31'h0, StallM}, 32'h1);
        reset = 1'b0;
        #1;
        chk("mr_stall", {31'h0, StallM},        32'h0);
        chk("mr_valid", {31'h0, bus_req_valid}, 32'h0);
        chk("mr_err",   {31'h0, BusErrM},       32'h0);
        chk("mr_addr",  bus_addr,               32'h0);
        MemReadM = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        bus_rsp_valid = 1'b1; bus_rdata = 32'h9999_9999; bus_rsp_err = 1'b1;
        @(negedge clk);
        bus_rsp_valid = 1'b0;
        #1;
        chk("stale_stall", {31'h0, StallM},  32'h0);
        chk("stale_rdata", ReadDataM,        32'h0);
        chk("stale_err",   {31'h0, BusErrM}, 32'h0);
        @(negedge clk);
        run_access("post_rst", 1'b1, 1'b0, 3'b010, 32'h0000_0304, 32'h0, 0, 0, 1'b1, 32'h0102_0304, 1'b0, 1'b0, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
